// File: rtl/fwd_stall_unit.sv
// ----------------------------------------------------------------------------
// fwd_stall_unit
//
// Purpose:
//   Hazard unit for a 5-stage MIPS-style pipeline. It tracks the in-flight
//   register writers in E, M and W in a small scoreboard, using {valid, addr,
//   tnew} for each. From this it decides whether the instruction in D must
//   stall. It also selects a forwarding source for every D-stage operand and
//   for every E-stage operand. A separate countdown models the multi-cycle
//   HI/LO unit so that HI/LO users wait until mult/div results are ready.
//
// Ports:
//   clk            - sole clock, rising edge
//   rst_n          - asynchronous active-low reset
//   d_src_addr_i   - D-stage source register addresses, port i at [i*AW +: AW]
//   d_src_used_i   - port i is actually read by the D instruction
//   d_src_tuse_i   - cycles until port i's value is consumed, port i at [i*TW +: TW]
//   d_dst_we_i     - D instruction writes the register file
//   d_dst_addr_i   - D instruction destination register
//   d_dst_tnew_i   - cycles after entering E until the result exists
//   d_md_start_i   - D instruction is mult/multu/div/divu
//   d_md_div_i     - with d_md_start_i: 1 = divide, 0 = multiply
//   d_md_use_i     - D instruction touches HI/LO
//   stall_o        - freeze F/D and insert a bubble into E
//   fwd_sel_d_o    - per D port (2 bits each): 0 RF, 1 E, 2 M, 3 W
//   fwd_sel_e_o    - per E port (2 bits each): 0 pipeline register, 2 M, 3 W
//   md_busy_o      - HI/LO unit busy
// ----------------------------------------------------------------------------
module fwd_stall_unit #(
    parameter int NSRC     = 2,
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC*AW-1:0]   d_src_addr_i,
    input  logic [NSRC-1:0]      d_src_used_i,
    input  logic [NSRC*TW-1:0]   d_src_tuse_i,
    input  logic                 d_dst_we_i,
    input  logic [AW-1:0]        d_dst_addr_i,
    input  logic [TW-1:0]        d_dst_tnew_i,
    input  logic                 d_md_start_i,
    input  logic                 d_md_div_i,
    input  logic                 d_md_use_i,
    output logic                 stall_o,
    output logic [NSRC*2-1:0]    fwd_sel_d_o,
    output logic [NSRC*2-1:0]    fwd_sel_e_o,
    output logic                 md_busy_o
);

    localparam int MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    // Scoreboard entries
    logic               eValid_q, mValid_q, wValid_q;
    logic [AW-1:0]      eAddr_q,  mAddr_q,  wAddr_q;
    logic [TW-1:0]      eTnew_q,  mTnew_q,  wTnew_q;

    // E-stage operand bookkeeping and HI/LO start flags
    logic [NSRC*AW-1:0] eSrcAddr_q;
    logic [NSRC-1:0]    eSrcUsed_q;
    logic               eMdStart_q, eMdDiv_q;

    // Next-state for the E entry
    logic               eValid_d;
    logic [NSRC-1:0]    eSrcUsed_d;
    logic               eMdStart_d;

    // HI/LO busy countdown
    logic [CW-1:0]      mdCnt_q, mdCnt_d;

    logic [NSRC-1:0]    portStall;
    logic [NSRC*2-1:0]  fwdSelD;
    logic [NSRC*2-1:0]  fwdSelE;
    logic               mdBusy;

    // A result never becomes "less ready" than 0.
    function automatic logic [TW-1:0] satDec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    // D-stage hazard check. The youngest writer (E first, then M, then W) owns
    // the register value. A not-yet-ready owner is never bypassed in favour of
    // an older stage, because that older value would be stale.
    always_comb begin : dStageCheck
        logic [AW-1:0] src;
        logic [TW-1:0] tuse;
        logic [TW-1:0] hitTnew;
        logic [1:0]    hitSel;
        logic          hit;
        portStall = '0;
        fwdSelD   = '0;
        src       = '0;
        tuse      = '0;
        hitTnew   = '0;
        hitSel    = 2'd0;
        hit       = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            src     = d_src_addr_i[i*AW +: AW];
            tuse    = d_src_tuse_i[i*TW +: TW];
            hit     = 1'b0;
            hitSel  = 2'd0;
            hitTnew = '0;
            if (d_src_used_i[i] && (src != '0)) begin
                if (eValid_q && (eAddr_q == src)) begin
                    hit     = 1'b1;
                    hitSel  = 2'd1;
                    hitTnew = eTnew_q;
                end else if (mValid_q && (mAddr_q == src)) begin
                    hit     = 1'b1;
                    hitSel  = 2'd2;
                    hitTnew = mTnew_q;
                end else if (wValid_q && (wAddr_q == src)) begin
                    hit     = 1'b1;
                    hitSel  = 2'd3;
                    hitTnew = wTnew_q;
                end
            end
            if (hit && (hitTnew > tuse)) begin
                portStall[i] = 1'b1;
            end
            if (hit && (hitTnew == '0)) begin
                fwdSelD[i*2 +: 2] = hitSel;
            end
        end
    end

    // E-stage operand bypass from M or W. Only ready results are forwarded.
    // Anything not ready was already handled by stalling the operand in D.
    always_comb begin : eStageCheck
        logic [AW-1:0] src;
        fwdSelE = '0;
        src     = '0;
        for (int i = 0; i < NSRC; i++) begin
            src = eSrcAddr_q[i*AW +: AW];
            if (eSrcUsed_q[i] && (src != '0)) begin
                if (mValid_q && (mAddr_q == src)) begin
                    if (mTnew_q == '0) begin
                        fwdSelE[i*2 +: 2] = 2'd2;
                    end
                end else if (wValid_q && (wAddr_q == src)) begin
                    if (wTnew_q == '0) begin
                        fwdSelE[i*2 +: 2] = 2'd3;
                    end
                end
            end
        end
    end

    // The HI/LO unit counts as busy in the very cycle a mult/div sits in E.
    // The countdown only starts on the following edge.
    always_comb begin
        mdBusy  = (mdCnt_q != '0) || eMdStart_q;
        mdCnt_d = mdCnt_q;
        if (eMdStart_q) begin
            mdCnt_d = eMdDiv_q ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (mdCnt_q != '0) begin
            mdCnt_d = mdCnt_q - 1'b1;
        end
    end

    // A stalled D instruction must not advance. E therefore receives a bubble
    // that writes nothing, reads nothing and starts nothing.
    always_comb begin
        stall_o    = (|portStall) || (d_md_use_i && mdBusy);
        eValid_d   = d_dst_we_i   && !stall_o;
        eMdStart_d = d_md_start_i && !stall_o;
        eSrcUsed_d = stall_o ? '0 : d_src_used_i;
    end

    assign fwd_sel_d_o = fwdSelD;
    assign fwd_sel_e_o = fwdSelE;
    assign md_busy_o   = mdBusy;

    // Scoreboard shift, E load and HI/LO countdown. Reset aborts everything
    // in flight, including a running divide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eValid_q   <= 1'b0;
            mValid_q   <= 1'b0;
            wValid_q   <= 1'b0;
            eAddr_q    <= '0;
            mAddr_q    <= '0;
            wAddr_q    <= '0;
            eTnew_q    <= '0;
            mTnew_q    <= '0;
            wTnew_q    <= '0;
            eSrcAddr_q <= '0;
            eSrcUsed_q <= '0;
            eMdStart_q <= 1'b0;
            eMdDiv_q   <= 1'b0;
            mdCnt_q    <= '0;
        end else begin
            wValid_q   <= mValid_q;
            wAddr_q    <= mAddr_q;
            wTnew_q    <= satDec(mTnew_q);
            mValid_q   <= eValid_q;
            mAddr_q    <= eAddr_q;
            mTnew_q    <= satDec(eTnew_q);
            eValid_q   <= eValid_d;
            eAddr_q    <= d_dst_addr_i;
            eTnew_q    <= d_dst_tnew_i;
            eSrcAddr_q <= d_src_addr_i;
            eSrcUsed_q <= eSrcUsed_d;
            eMdStart_q <= eMdStart_d;
            eMdDiv_q   <= d_md_div_i;
            mdCnt_q    <= mdCnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_stall_unit.sv
// ----------------------------------------------------------------------------
// tb_fwd_stall_unit
//
// Purpose:
//   Directed bench for fwd_stall_unit with the default parameters (NSRC=2,
//   AW=5, TW=2, MULT_CYC=5, DIV_CYC=10). Each step drives one D-stage
//   instruction just after a rising edge. The outputs are then compared
//   against hand-derived values on the falling edge.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_fwd_stall_unit;

    logic        clk;
    logic        rst_n;
    logic [9:0]  srcAddr;
    logic [1:0]  srcUsed;
    logic [3:0]  srcTuse;
    logic        dstWe;
    logic [4:0]  dstAddr;
    logic [1:0]  dstTnew;
    logic        mdStart;
    logic        mdDiv;
    logic        mdUse;
    logic        stall;
    logic [3:0]  fwdSelD;
    logic [3:0]  fwdSelE;
    logic        mdBusy;

    int compared   = 0;
    int mismatched = 0;

    fwd_stall_unit #(
        .NSRC(2), .AW(5), .TW(2), .MULT_CYC(5), .DIV_CYC(10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .d_src_addr_i (srcAddr),
        .d_src_used_i (srcUsed),
        .d_src_tuse_i (srcTuse),
        .d_dst_we_i   (dstWe),
        .d_dst_addr_i (dstAddr),
        .d_dst_tnew_i (dstTnew),
        .d_md_start_i (mdStart),
        .d_md_div_i   (mdDiv),
        .d_md_use_i   (mdUse),
        .stall_o      (stall),
        .fwd_sel_d_o  (fwdSelD),
        .fwd_sel_e_o  (fwdSelE),
        .md_busy_o    (mdBusy)
    );

    // 10 ns clock; rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one D-stage instruction: two source ports plus destination and HI/LO info.
    task automatic applyStimulus(
        input logic [4:0] a0, input logic u0, input logic [1:0] t0,
        input logic [4:0] a1, input logic u1, input logic [1:0] t1,
        input logic we, input logic [4:0] dst, input logic [1:0] tn,
        input logic ms, input logic md, input logic mu);
        srcAddr = {a1, a0};
        srcUsed = {u1, u0};
        srcTuse = {t1, t0};
        dstWe   = we;
        dstAddr = dst;
        dstTnew = tn;
        mdStart = ms;
        mdDiv   = md;
        mdUse   = mu;
    endtask

    task automatic applyNop();
        applyStimulus(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Clear the scoreboard by pushing nops through E, M and W.
    task automatic flush();
        applyNop();
        repeat (3) nextCycle();
    endtask

    task automatic checkOutput(input string tag, input logic expStall,
                               input logic [3:0] expFwdD, input logic [3:0] expFwdE,
                               input logic expBusy);
        compared++;
        assert (stall === expStall) else begin
            mismatched++;
            $error("[TB] FAIL %s stall: observed %0b expected %0b", tag, stall, expStall);
        end
        compared++;
        assert (fwdSelD === expFwdD) else begin
            mismatched++;
            $error("[TB] FAIL %s fwd_sel_d: observed %b expected %b", tag, fwdSelD, expFwdD);
        end
        compared++;
        assert (fwdSelE === expFwdE) else begin
            mismatched++;
            $error("[TB] FAIL %s fwd_sel_e: observed %b expected %b", tag, fwdSelE, expFwdE);
        end
        compared++;
        assert (mdBusy === expBusy) else begin
            mismatched++;
            $error("[TB] FAIL %s md_busy: observed %0b expected %0b", tag, mdBusy, expBusy);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyNop();
        mdUse = 1'b1;
        #3;
        checkOutput("in_reset", 1'b0, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        nextCycle();
        applyNop();
        @(negedge clk);
        checkOutput("after_reset", 1'b0, 4'b0000, 4'b0000, 1'b0);

        // lw $2 (tnew=2) followed by beq on $2 (tuse=0)
        nextCycle();
        applyStimulus(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd2, 2'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("lw_in_d", 1'b0, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        applyStimulus(5'd2, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("lw_beq_stall1", 1'b1, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("lw_beq_stall2", 1'b1, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("lw_beq_fwd_w", 1'b0, 4'b0011, 4'b0000, 1'b0);
        nextCycle();
        flush();

        // addu $3 (tnew=1), then reader of $3/$4 in E (tuse=1), then beq on $3
        applyStimulus(5'd1, 1'b1, 2'd1, 5'd2, 1'b1, 2'd1, 1'b1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("addu_in_d", 1'b0, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        applyStimulus(5'd3, 1'b1, 2'd1, 5'd4, 1'b1, 2'd1, 1'b1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("addu_reader_no_stall", 1'b0, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 1'b0, 2'd0, 5'd3, 1'b1, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reader_e_fwd_m", 1'b0, 4'b1000, 4'b0010, 1'b0);
        nextCycle();
        applyNop();
        @(negedge clk);
        checkOutput("beq_e_fwd_w", 1'b0, 4'b0000, 4'b1100, 1'b0);
        nextCycle();
        flush();

        // ori $0 then beq $0,$0: register 0 never matches
        applyStimulus(5'd1, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 1'b1, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("ori_r0_in_d", 1'b0, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("beq_r0_no_match", 1'b0, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        flush();

        // Two writers of $5 back to back, reader tuse=0: E entry wins and stalls
        applyStimulus(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("writer_a_in_d", 1'b0, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("writer_b_in_d", 1'b0, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        applyStimulus(5'd5, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("e_match_wins_stall", 1'b1, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("m_beats_w", 1'b0, 4'b0010, 4'b0000, 1'b0);
        nextCycle();
        flush();

        // div then mflo: 11 stalled cycles counted from div-in-E
        applyStimulus(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("div_in_d", 1'b0, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        applyStimulus(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            checkOutput($sformatf("mflo_stall_%0d", k), 1'b1, 4'b0000, 4'b0000, 1'b1);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("mflo_release", 1'b0, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        flush();

        // mult busy, then asynchronous reset mid-busy
        applyStimulus(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("mult_in_d", 1'b0, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        applyNop();
        @(negedge clk);
        checkOutput("mult_in_e_busy", 1'b0, 4'b0000, 4'b0000, 1'b1);
        nextCycle();
        mdUse = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_during_mult", 1'b0, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("after_rst_mult", 1'b0, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        flush();

        // lw $7 then beq $7 stalls; reset during the stall clears it
        applyStimulus(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("lw7_in_d", 1'b0, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        applyStimulus(5'd7, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("beq7_stall", 1'b1, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_during_stall", 1'b0, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("after_rst_stall", 1'b0, 4'b0000, 4'b0000, 1'b0);
        nextCycle();
        applyNop();
        @(negedge clk);
        checkOutput("no_spurious_fwd", 1'b0, 4'b0000, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
